seg_text_scroller: RTL and testbench

- Message sequencer for the 6-digit ASCII seven-segment display driver.
- Accepts a text string over a valid/ready byte interface into a local buffer, then scrolls it right-to-left across the six digits at a programmable step rate.
- Drives the driver's char0..char5 and en inputs; char5 is the leftmost digit and char0 the rightmost.
- Code 0x00 is a blank digit.

---
 rtl/seg_text_scroller.sv | 205 ++++++++++++++++++++
 tb/tb_seg_text_scroller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_text_scroller.sv
// Message sequencer for the 6-digit ASCII seven-segment driver.
// Buffers a text string received over a valid/ready byte interface, then
// scrolls it right-to-left across char5 (leftmost) .. char0 (rightmost).
// Optional macro SEG_SCROLL_BLINK_EN adds a HOLD state that blinks the
// first six characters three times after a non-repeating pass.
module seg_text_scroller #(
  parameter logic [23:0] STEP_DIV  = 24'd12_500_000,
  parameter int unsigned BUF_DEPTH = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  input  logic       repeat_en,  // restart request ("repeat" is reserved in SV)
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       en,
  output logic [7:0] char0,
  output logic [7:0] char1,
  output logic [7:0] char2,
  output logic [7:0] char3,
  output logic [7:0] char4,
  output logic [7:0] char5
);

  localparam int unsigned LW = ADDR_W + 1;  // pos / msg_len width
  localparam int unsigned IW = ADDR_W + 2;  // virtual index width (pos + 5)

`ifdef SEG_SCROLL_BLINK_EN
  typedef enum logic [1:0] {ST_LOAD, ST_SCROLL, ST_HOLD} state_t;
`else
  typedef enum logic [1:0] {ST_LOAD, ST_SCROLL} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     msg_len_q, msg_len_d;
  logic [LW-1:0]     pos_q, pos_d;
  logic [23:0]       step_q, step_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic [5:0][7:0]   char_q, char_d;
`ifdef SEG_SCROLL_BLINK_EN
  logic [2:0]        blink_cnt_q, blink_cnt_d;
`endif

  logic [7:0]        msg_mem_q [BUF_DEPTH];
  logic [IW-1:0]     vi;
  logic              accept;
  logic              tick;
  logic              last_pos;

  assign wr_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_LOAD);
  assign done     = done_q;
  assign en       = en_q;
  assign char0    = char_q[0];
  assign char1    = char_q[1];
  assign char2    = char_q[2];
  assign char3    = char_q[3];
  assign char4    = char_q[4];
  assign char5    = char_q[5];

  assign accept   = wr_valid && wr_ready && !abort;
  assign tick     = (state_q != ST_LOAD) && (step_q == STEP_DIV - 24'd1);
  assign last_pos = (pos_q == msg_len_q + LW'(5));

  // Next-state logic: load, scroll stepping, end-of-pass and abort handling.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    msg_len_d = msg_len_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    step_d    = (state_q == ST_LOAD) ? '0 : (tick ? '0 : step_q + 24'd1);
`ifdef SEG_SCROLL_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_last || (wr_ptr_q == ADDR_W'(BUF_DEPTH - 1))) begin
            msg_len_d = LW'(wr_ptr_q) + LW'(1);
            pos_d     = '0;
            step_d    = '0;
            state_d   = ST_SCROLL;
          end
        end
      end
      ST_SCROLL: begin
        if (tick) begin
          if (!last_pos) begin
            pos_d = pos_q + LW'(1);
          end else if (repeat_en) begin
            pos_d = '0;
          end else begin
`ifdef SEG_SCROLL_BLINK_EN
            state_d     = ST_HOLD;
            blink_cnt_d = '0;
`else
            state_d  = ST_LOAD;
            done_d   = 1'b1;
            wr_ptr_d = '0;
            pos_d    = '0;
`endif
          end
        end
      end
`ifdef SEG_SCROLL_BLINK_EN
      ST_HOLD: begin
        if (tick) begin
          if (blink_cnt_q == 3'd6) begin
            state_d  = ST_LOAD;
            done_d   = 1'b1;
            wr_ptr_d = '0;
            pos_d    = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + 3'd1;
          end
        end
      end
`endif
      default: state_d = ST_LOAD;
    endcase
    if (abort) begin
      state_d  = ST_LOAD;
      wr_ptr_d = '0;
      pos_d    = '0;
      step_d   = '0;
      done_d   = 1'b0;
    end
  end

  // Display next-value: blanking follows the next state so abort and pass
  // end clear immediately, while the scroll window lags pos by one cycle.
  always_comb begin
    en_d   = 1'b0;
    char_d = '0;
    vi     = '0;
    case (state_d)
      ST_SCROLL: begin
        en_d = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
          vi = IW'(pos_q) + IW'(k);
          if ((vi >= IW'(6)) && (vi < IW'(msg_len_q) + IW'(6))) begin
            char_d[3'(5 - k)] = msg_mem_q[ADDR_W'(vi - IW'(6))];
          end
        end
      end
`ifdef SEG_SCROLL_BLINK_EN
      ST_HOLD: begin
        en_d = (state_q == ST_HOLD) ? (tick ? ~en_q : en_q) : 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
          if (LW'(k) < msg_len_q) begin
            char_d[3'(5 - k)] = msg_mem_q[ADDR_W'(k)];
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Control and display registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      wr_ptr_q  <= '0;
      msg_len_q <= '0;
      pos_q     <= '0;
      step_q    <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      char_q    <= '0;
`ifdef SEG_SCROLL_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      msg_len_q <= msg_len_d;
      pos_q     <= pos_d;
      step_q    <= step_d;
      en_q      <= en_d;
      done_q    <= done_d;
      char_q    <= char_d;
`ifdef SEG_SCROLL_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  // Message buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      msg_mem_q[wr_ptr_q] <= wr_char;
    end
  end

endmodule

// File: tb/tb_seg_text_scroller.sv
// Scoreboard bench for seg_text_scroller (STEP_DIV=4). Stimulus pushes the
// expected sequence of output frames {busy,en,done,wr_ready,char5..char0}
// with the cycle distance from the previous frame; a monitor pops one entry
// each time the sampled outputs change.
module tb_seg_text_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char = '0;
  logic       wr_last = 1'b0;
  logic       repeat_en = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, en;
  logic [7:0] char0, char1, char2, char3, char4, char5;

  seg_text_scroller #(
    .STEP_DIV (24'd4),
    .BUF_DEPTH(32),
    .ADDR_W   (5)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .repeat_en(repeat_en),
    .abort(abort), .busy(busy), .done(done), .en(en),
    .char0(char0), .char1(char1), .char2(char2),
    .char3(char3), .char4(char4), .char5(char5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [51:0] obs;
    int unsigned dl;   // cycles since previous frame, 0 = not checked
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  logic [51:0] prev = 'x;
  logic [7:0]  tmsg [32];
  int unsigned tlen = 0;

  function automatic logic [51:0] fr(input logic b, input logic e,
                                     input logic d, input logic r,
                                     input logic [47:0] ch);
    return {b, e, d, r, ch};
  endfunction

  function automatic logic [51:0] cur_obs();
    return {busy, en, done, wr_ready, char5, char4, char3, char2, char1, char0};
  endfunction

  // V[i] = msg[i-6] for 6 <= i < 6+len; char5 = V[p] .. char0 = V[p+5]
  function automatic logic [47:0] view(input int unsigned p);
    logic [47:0] r;
    r = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (p + k >= 6 && p + k < 6 + tlen) r[(5 - k) * 8 +: 8] = tmsg[p + k - 6];
    end
    return r;
  endfunction

  function automatic logic [47:0] hold_view();
    logic [47:0] r;
    r = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (k < tlen) r[(5 - k) * 8 +: 8] = tmsg[k];
    end
    return r;
  endfunction

  task automatic push(input logic [51:0] o, input int unsigned dl);
    exp_t e;
    e.obs = o;
    e.dl  = dl;
    q.push_back(e);
  endtask

  task automatic push_frames(input int unsigned first_dl);
    for (int unsigned p = 1; p <= tlen + 5; p++)
      push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(p)), (p == 1) ? first_dl : 4);
  endtask

  task automatic push_end();
`ifdef SEG_SCROLL_BLINK_EN
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, hold_view()), 3);
    for (int unsigned t = 0; t < 6; t++)
      push(fr(1'b1, t[0], 1'b0, 1'b0, hold_view()), 4);
    push(fr(1'b0, 1'b0, 1'b1, 1'b1, '0), 4);
`else
    push(fr(1'b0, 1'b0, 1'b1, 1'b1, '0), 3);
`endif
    push(fr(1'b0, 1'b0, 1'b0, 1'b1, '0), 1);
  endtask

  task automatic tick_n(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] c, input logic l);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = l;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d frames still pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: every change of the sampled outputs is one comparison.
  always @(negedge clk) begin
    logic [51:0] c;
    exp_t        e;
    cyc++;
    c = cur_obs();
    if (c !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %h at cycle %0d, required no change", c, cyc);
      end else begin
        e = q.pop_front();
        if (c !== e.obs || (e.dl != 0 && cyc - last_cyc != e.dl)) begin
          errors++;
          $display("FAIL frame: got %h after %0d cycles, required %h after %0d cycles",
                   c, cyc - last_cyc, e.obs, e.dl);
        end
      end
      last_cyc = cyc;
      prev     = c;
    end
  end

  localparam logic [51:0] RESET_FRAME = {4'b0001, 48'h0};
  localparam logic [51:0] ENTRY_FRAME = {4'b1100, 48'h0};

  initial begin
    push(RESET_FRAME, 0);
    tick_n(3);
    rst = 1'b0;
    tick_n(2);

    // Basic pass "HI"
    tmsg[0] = 8'h48; tmsg[1] = 8'h49; tlen = 2;
    push(ENTRY_FRAME, 0);
    push({4'b1100, 48'h00_00_00_00_00_48}, 5);
    push({4'b1100, 48'h00_00_00_00_48_49}, 4);
    push({4'b1100, 48'h00_00_00_48_49_00}, 4);
    push({4'b1100, 48'h00_00_48_49_00_00}, 4);
    push({4'b1100, 48'h00_48_49_00_00_00}, 4);
    push({4'b1100, 48'h48_49_00_00_00_00}, 4);
    push({4'b1100, 48'h49_00_00_00_00_00}, 4);
    push_end();
    wr(8'h48, 1'b0);
    wr(8'h49, 1'b1);
    drain("basic_hi", 300);

    // Repeat "A": one repeated pass, then repeat dropped
    tmsg[0] = 8'h41; tlen = 1;
    repeat_en = 1'b1;
    push(ENTRY_FRAME, 0);
    push_frames(5);
    push(ENTRY_FRAME, 4);
    push_frames(4);
    push_end();
    wr(8'h41, 1'b1);
    tick_n(40);
    repeat_en = 1'b0;
    drain("repeat", 300);

    // Buffer full: 32 chars without wr_last, 33rd request refused
    for (int unsigned i = 0; i < 32; i++) tmsg[i] = 8'(8'h40 + i);
    tlen = 32;
    push(ENTRY_FRAME, 0);
    push_frames(5);
    push_end();
    for (int unsigned i = 0; i < 32; i++) wr(tmsg[i], 1'b0);
    wr_valid = 1'b1;
    wr_char  = 8'h5A;
    tick_n(10);
    wr_valid = 1'b0;
    drain("buffer_full", 400);

    // Abort in LOAD (with simultaneous write), then abort mid-scroll of "AB"
    wr(8'h58, 1'b0);
    wr_valid = 1'b1; wr_char = 8'h59; abort = 1'b1;
    tick_n(1);
    wr_valid = 1'b0; abort = 1'b0;
    tmsg[0] = 8'h41; tmsg[1] = 8'h42; tlen = 2;
    push(ENTRY_FRAME, 0);
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(1)), 5);
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(2)), 4);
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(3)), 4);
    push(RESET_FRAME, 2);
    wr(8'h41, 1'b0);
    wr(8'h42, 1'b1);
    tick_n(14);
    abort = 1'b1;
    tick_n(1);
    abort = 1'b0;
    drain("abort_scroll", 100);
    tick_n(10);

    // New message "7" after abort starts from buffer slot 0
    tmsg[0] = 8'h37; tlen = 1;
    push(ENTRY_FRAME, 0);
    push_frames(5);
    push_end();
    wr(8'h37, 1'b1);
    drain("after_abort", 300);

    // Asynchronous reset mid-scroll
    tmsg[0] = 8'h48; tmsg[1] = 8'h49; tlen = 2;
    push(ENTRY_FRAME, 0);
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(1)), 5);
    push(fr(1'b1, 1'b1, 1'b0, 1'b0, view(2)), 4);
    push(RESET_FRAME, 0);
    wr(8'h48, 1'b0);
    wr(8'h49, 1'b1);
    tick_n(10);
    rst = 1'b1;
    #1;
    checks++;
    if (cur_obs() !== RESET_FRAME) begin
      errors++;
      $display("FAIL async_reset: got %h, required %h", cur_obs(), RESET_FRAME);
    end
    tick_n(2);
    rst = 1'b0;
    tick_n(3);
    drain("reset_mid", 50);
    tick_n(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
